// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX feeder state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_WAIT  = ST_WAIT
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and synchronous flush.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ready_o = (level_q != FULL);
  assign push_ok      = push_valid_i & push_ready_o & ~flush_i;
  assign pop_ok       = pop_i & (level_q != '0) & ~flush_i;
  assign rd_data_o    = mem_q[rptr_q];
  assign level_o      = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is intentionally not reset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them to the UART transmitter one frame at a time
// using a start_tx pulse / tx_done handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic [AW:0]       level,
  output logic              busy,
  output logic              start_tx,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done
);

  feeder_state_e     state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] fifo_rd;
  logic              pop;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .push_valid_i (wr_valid),
    .push_data_i  (wr_data),
    .push_ready_o (wr_ready),
    .pop_i        (pop),
    .rd_data_o    (fifo_rd),
    .level_o      (level)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE:  if ((level != '0) && !flush) state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = fifo_rd;
        pop       = 1'b1;
        state_d   = S_START;
      end
      S_START: state_d = S_WAIT;
      // A flush leaves an in-flight frame alone; only tx_done ends it.
      S_WAIT:  if (tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign start_tx = (state_q == S_START);
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE) | (level != '0);

endmodule
